// File: rtl/axis_traffic_gen_pkg.sv
// Shared types and helpers for the AXI-Stream traffic generator.
// Holds the FSM state encoding, the sequence width and lane replication.
package axis_traffic_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int SEQ_WIDTH      = 32;
    localparam int MAX_DATA_WIDTH = 4096;

    // Replicates seq into every 32-bit lane; callers size-cast the result
    // down to their own DATA_WIDTH.
    function automatic logic [MAX_DATA_WIDTH-1:0] replicate_seq(
        input logic [SEQ_WIDTH-1:0] seq
    );
        return {(MAX_DATA_WIDTH/SEQ_WIDTH){seq}};
    endfunction

endpackage

// File: rtl/axis_traffic_gen_rate.sv
// Window-based beat credit for the traffic generator.
// Ports: clk, reset (sync, high), run (generator active), bpw (budget per
// window), issue (a beat is issued this cycle), credit_avail (may issue).
module rate_credit_limiter #(
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_CYCLES = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [COUNTER_WIDTH-1:0] bpw,
    input  logic                     issue,
    output logic                     credit_avail
);

    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic [WW-1:0]            win_q, win_d;
    logic [COUNTER_WIDTH-1:0] credit_q, credit_d;
    logic                     wrap;

    assign wrap = (win_q == WW'(WINDOW_CYCLES - 1));

    // On the wrap cycle the freshly reloaded budget decides, so an issue
    // in that cycle is charged to the new window.
    assign credit_avail = wrap ? (bpw != '0) : (credit_q != '0);

    always_comb begin
        win_d    = win_q;
        credit_d = credit_q;
        if (!run) begin
            // Keeps the budget primed so RUN entry starts a fresh window.
            win_d    = '0;
            credit_d = bpw;
        end else begin
            win_d    = wrap ? '0 : win_q + WW'(1);
            credit_d = (wrap ? bpw : credit_q)
                     - (issue ? COUNTER_WIDTH'(1) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q    <= '0;
            credit_q <= '0;
        end else begin
            win_q    <= win_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/axis_traffic_gen.sv
// Rate-limited AXI-Stream source emitting replicated sequence numbers.
// Ports: clk, reset, enable, beats_per_window, pkt_len in; tdata, tvalid,
// tlast, beats_sent, busy out; tready in (full backpressure honoured).
module axis_traffic_gen
    import axis_traffic_gen_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_CYCLES = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] beats_per_window,
    input  logic [15:0]              pkt_len,
    output logic [DATA_WIDTH-1:0]    tdata,
    output logic                     tvalid,
    input  logic                     tready,
    output logic                     tlast,
    output logic [COUNTER_WIDTH-1:0] beats_sent,
    output logic                     busy
);

    state_e                   state_q, state_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic [SEQ_WIDTH-1:0]     cur_seq_q, cur_seq_d;
    logic [SEQ_WIDTH-1:0]     seq_q, seq_d;
    logic [15:0]              idx_q, idx_d;
    logic [15:0]              plen_q, plen_d;
    logic [COUNTER_WIDTH-1:0] bs_q, bs_d;

    logic        hs;
    logic        can_present;
    logic        pkt_open;
    logic        credit_avail;
    logic        issue;
    logic        run;
    logic        last_beat;
    logic [15:0] plen_new;
    logic [15:0] plen_eff;

    assign hs          = tvalid_q & tready;
    assign can_present = ~tvalid_q | hs;
    assign pkt_open    = (idx_q != 16'd0);
    assign run         = (state_q != IDLE);
    assign plen_new    = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
    assign plen_eff    = pkt_open ? plen_q : plen_new;
    assign last_beat   = (idx_q == plen_eff - 16'd1);

    rate_credit_limiter #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_rate (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .bpw          (beats_per_window),
        .issue        (issue),
        .credit_avail (credit_avail)
    );

    always_comb begin
        state_d   = state_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        cur_seq_d = cur_seq_q;
        seq_d     = seq_q;
        idx_d     = idx_q;
        plen_d    = plen_q;
        bs_d      = bs_q;
        issue     = 1'b0;

        if (hs && !(&bs_q)) begin
            bs_d = bs_q + COUNTER_WIDTH'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    seq_d   = '0;
                    idx_d   = '0;
                    bs_d    = '0;
                end
            end
            RUN: begin
                // With enable low only an open packet may continue.
                issue = can_present & credit_avail & (enable | pkt_open);
                if (!enable) begin
                    // A tlast beat retiring this cycle closes the packet.
                    if (pkt_open || (tvalid_q && !(hs && tlast_q))) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                issue = can_present & credit_avail & pkt_open;
                if ((hs && tlast_q) || (!tvalid_q && !pkt_open)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            tvalid_d  = 1'b1;
            tlast_d   = last_beat;
            cur_seq_d = seq_q;
            seq_d     = seq_q + SEQ_WIDTH'(1);
            idx_d     = last_beat ? 16'd0 : idx_q + 16'd1;
            if (!pkt_open) begin
                plen_d = plen_new;
            end
        end else if (hs) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            cur_seq_q <= '0;
            seq_q     <= '0;
            idx_q     <= '0;
            plen_q    <= 16'd1;
            bs_q      <= '0;
        end else begin
            state_q   <= state_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            cur_seq_q <= cur_seq_d;
            seq_q     <= seq_d;
            idx_q     <= idx_d;
            plen_q    <= plen_d;
            bs_q      <= bs_d;
        end
    end

    assign tdata      = DATA_WIDTH'(replicate_seq(cur_seq_q));
    assign tvalid     = tvalid_q;
    assign tlast      = tlast_q;
    assign beats_sent = bs_q;
    assign busy       = run;

endmodule
